// File: rtl/spi_mem_loader_if.sv
// Memory write port bundle between the serial loader and the imem/dmem arrays.
// Loader drives strobe, address and byte; the memories only listen, no backpressure.
interface spi_mem_loader_if #(
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 4
);
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [7:0]         imem_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [7:0]         dmem_wdata;

  modport master (
    output imem_we, imem_addr, imem_wdata,
    output dmem_we, dmem_addr, dmem_wdata
  );

  modport slave (
    input imem_we, imem_addr, imem_wdata,
    input dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/spi_mem_loader.sv
// Serial byte loader into imem/dmem; strobe lands 3 cycles after the 8th bit is on the pin, no backpressure.
// LOADER_CHECKSUM_EN adds a running XOR of written bytes; otherwise checksum is tied to zero.
module spi_mem_loader #(
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_en,
  input  logic                  csi,
  input  logic                  csd,
  input  logic                  mosi,
  spi_mem_loader_if.master      mem,
  output logic                  busy,
  output logic                  load_done,
  output logic                  overflow,
  output logic                  frame_err,
  output logic [7:0]            checksum
);

  localparam int CW = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;
  localparam logic [CW-1:0] IDEPTH = CW'(1) << IMEM_AW;
  localparam logic [CW-1:0] DDEPTH = CW'(1) << DMEM_AW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    LOAD_D = 3'd2,
    ERR    = 3'd3,
    LOCKED = 3'd4
  } state_t;

  state_t state, nxt;

  // Equal-depth synchronisers keep select and data edges aligned to each other.
  logic csi_m, csi_s, csd_m, csd_s, mosi_m, mosi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csi_m  <= 1'b1;
      csi_s  <= 1'b1;
      csd_m  <= 1'b1;
      csd_s  <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      csi_m  <= csi;
      csi_s  <= csi_m;
      csd_m  <= csd;
      csd_s  <= csd_m;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  logic [7:0]         sr;
  logic [2:0]         bcnt;
  logic [CW-1:0]      cnt;
  logic               imem_we_q, dmem_we_q;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic [DMEM_AW-1:0] dmem_addr_q;
  logic [7:0]         imem_wdata_q, dmem_wdata_q;

  logic       frame_start, shifting, byte_done, full, do_wr, frame_end_ok;
  logic [7:0] new_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt          = state;
    frame_start  = 1'b0;
    shifting     = 1'b0;
    frame_end_ok = 1'b0;
    full         = 1'b0;
    case (state)
      IDLE: begin
        if (proc_en)               nxt = LOCKED;
        else if (!csi_s && !csd_s) nxt = ERR;
        else if (!csi_s)           nxt = LOAD_I;
        else if (!csd_s)           nxt = LOAD_D;
        frame_start = (nxt != IDLE) && (nxt != LOCKED);
      end
      LOAD_I: begin
        full = (cnt == IDEPTH);
        if (!csd_s)     nxt = ERR;
        else if (csi_s) nxt = IDLE;
        shifting     = (nxt == LOAD_I);
        frame_end_ok = (nxt == IDLE);
      end
      LOAD_D: begin
        full = (cnt == DDEPTH);
        if (!csi_s)     nxt = ERR;
        else if (csd_s) nxt = IDLE;
        shifting     = (nxt == LOAD_D);
        frame_end_ok = (nxt == IDLE);
      end
      ERR: begin
        if (csi_s && csd_s) nxt = IDLE;
      end
      LOCKED: begin
        if (!proc_en && csi_s && csd_s) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    new_byte  = {sr[6:0], mosi_s};
    byte_done = shifting && (bcnt == 3'd7);
    do_wr     = byte_done && !full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr           <= '0;
      bcnt         <= '0;
      cnt          <= '0;
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      dmem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_wdata_q <= '0;
      load_done    <= 1'b0;
      overflow     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      load_done <= 1'b0;
      if (frame_start) begin
        sr        <= '0;
        bcnt      <= '0;
        cnt       <= '0;
        overflow  <= 1'b0;
        frame_err <= 1'b0;
      end
      if (shifting) begin
        sr   <= new_byte;
        bcnt <= bcnt + 3'd1;
      end
      if (do_wr) begin
        cnt <= cnt + CW'(1);
        if (state == LOAD_I) begin
          imem_we_q    <= 1'b1;
          imem_addr_q  <= cnt[IMEM_AW-1:0];
          imem_wdata_q <= new_byte;
        end else begin
          dmem_we_q    <= 1'b1;
          dmem_addr_q  <= cnt[DMEM_AW-1:0];
          dmem_wdata_q <= new_byte;
        end
      end
      // Past the last location the byte is dropped and the address parks at depth.
      if (byte_done && full) overflow <= 1'b1;
      if (nxt == ERR) frame_err <= 1'b1;
      if (frame_end_ok && (cnt != '0)) load_done <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           chk <= '0;
    else if (frame_start) chk <= '0;
    else if (do_wr)       chk <= chk ^ new_byte;
  end

  assign checksum = chk;
`else
  assign checksum = 8'h00;
`endif

  assign busy           = (state == LOAD_I) || (state == LOAD_D) || (state == ERR);
  assign mem.imem_we    = imem_we_q;
  assign mem.imem_addr  = imem_addr_q;
  assign mem.imem_wdata = imem_wdata_q;
  assign mem.dmem_we    = dmem_we_q;
  assign mem.dmem_addr  = dmem_addr_q;
  assign mem.dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed bench for spi_mem_loader: frame table plus hand sequences for error, lock and reset cases.
module tb_spi_mem_loader;
  localparam int AW = 4;

  logic       clk = 1'b0;
  logic       rst_n, proc_en, csi, csd, mosi;
  logic       busy, load_done, overflow, frame_err;
  logic [7:0] checksum;

  spi_mem_loader_if #(.IMEM_AW(AW), .DMEM_AW(AW)) mem ();

  spi_mem_loader #(.IMEM_AW(AW), .DMEM_AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .proc_en   (proc_en),
    .csi       (csi),
    .csd       (csd),
    .mosi      (mosi),
    .mem       (mem),
    .busy      (busy),
    .load_done (load_done),
    .overflow  (overflow),
    .frame_err (frame_err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         use_d;
    bit         lock;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    int         extra;
    int         ew;
    int         ed;
    bit         eo;
    logic [7:0] chk;
  } vec_t;

  typedef struct {
    bit         is_d;
    int         addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  vec_t vecs[7];
  wr_t  wq[$];
  int   done_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gen(input vec_t v, input int k);
    if (k == 0) return v.b0;
    if (k == 1) return v.b1;
    return 8'(k);
  endfunction

  always @(negedge clk) begin
    if (mem.imem_we || mem.dmem_we)
      check("one_strobe", {31'd0, mem.imem_we & mem.dmem_we}, 32'd0);
    if (mem.imem_we) wq.push_back('{1'b0, int'(mem.imem_addr), mem.imem_wdata, cyc});
    if (mem.dmem_we) wq.push_back('{1'b1, int'(mem.dmem_addr), mem.dmem_wdata, cyc});
    if (load_done) done_cnt++;
  end

  task automatic run_vec(input vec_t v);
    int         first_cyc;
    logic [7:0] b;
    logic [7:0] exp_chk;
    first_cyc = 0;
    wq.delete();
    done_cnt = 0;
    proc_en  = v.lock;
    repeat (3) tick();
    if (v.use_d) csd = 1'b0;
    else         csi = 1'b0;
    tick();
    for (int k = 0; k < v.nbytes; k++) begin
      b = gen(v, k);
      for (int i = 7; i >= 0; i--) begin
        mosi = b[i];
        if (k == 0 && i == 0) first_cyc = cyc;
        tick();
      end
    end
    for (int i = 0; i < v.extra; i++) begin
      mosi = 1'b1;
      tick();
    end
    csi  = 1'b1;
    csd  = 1'b1;
    mosi = 1'b0;
    repeat (8) tick();
    proc_en = 1'b0;
    repeat (3) tick();

    check("n_writes", wq.size(), v.ew);
    foreach (wq[k]) begin
      check("wr_mem", {31'd0, wq[k].is_d}, {31'd0, v.use_d});
      check("wr_addr", wq[k].addr, k);
      check("wr_data", {24'd0, wq[k].data}, {24'd0, gen(v, k)});
      if (k == 0) check("wr_latency", wq[k].cyc - first_cyc, 3);
      else        check("wr_spacing", wq[k].cyc - wq[k-1].cyc, 8);
    end
`ifdef LOADER_CHECKSUM_EN
    exp_chk = v.chk;
`else
    exp_chk = 8'h00;
`endif
    check("load_done_cnt", done_cnt, v.ed);
    check("overflow", {31'd0, overflow}, {31'd0, v.eo});
    check("checksum", {24'd0, checksum}, {24'd0, exp_chk});
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //                use_d lock  n   b0     b1    extra ew  ed  eo    chk
    vecs[0] = '{1'b0, 1'b0, 2,  8'hA5, 8'h3C, 0, 2,  1, 1'b0, 8'h99};
    vecs[1] = '{1'b1, 1'b0, 17, 8'hF0, 8'h0F, 0, 16, 1, 1'b1, 8'hFE};
    vecs[2] = '{1'b0, 1'b0, 0,  8'h00, 8'h00, 5, 0,  0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 1,  8'h5A, 8'h00, 0, 1,  1, 1'b0, 8'h5A};
    vecs[4] = '{1'b0, 1'b1, 1,  8'hFF, 8'h00, 0, 0,  0, 1'b0, 8'h5A};
    vecs[5] = '{1'b0, 1'b0, 1,  8'hFF, 8'h00, 0, 1,  1, 1'b0, 8'hFF};
    vecs[6] = '{1'b1, 1'b0, 3,  8'h01, 8'h80, 0, 3,  1, 1'b0, 8'h83};

    rst_n   = 1'b0;
    proc_en = 1'b0;
    csi     = 1'b1;
    csd     = 1'b1;
    mosi    = 1'b0;
    repeat (3) tick();
    check("rst_imem_we",    {31'd0, mem.imem_we}, 32'd0);
    check("rst_imem_addr",  {28'd0, mem.imem_addr}, 32'd0);
    check("rst_imem_wdata", {24'd0, mem.imem_wdata}, 32'd0);
    check("rst_dmem_we",    {31'd0, mem.dmem_we}, 32'd0);
    check("rst_dmem_addr",  {28'd0, mem.dmem_addr}, 32'd0);
    check("rst_dmem_wdata", {24'd0, mem.dmem_wdata}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_load_done",  {31'd0, load_done}, 32'd0);
    check("rst_overflow",   {31'd0, overflow}, 32'd0);
    check("rst_frame_err",  {31'd0, frame_err}, 32'd0);
    check("rst_checksum",   {24'd0, checksum}, 32'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_no_strobe", wq.size(), 0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Second select falling mid-byte: error holds until both selects are high.
    wq.delete();
    done_cnt = 0;
    csi = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      tick();
    end
    csd = 1'b0;
    repeat (5) tick();
    check("err_flag", {31'd0, frame_err}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd1);
    csi = 1'b1;
    mosi = 1'b0;
    repeat (5) tick();
    check("err_busy_one_high", {31'd0, busy}, 32'd1);
    csd = 1'b1;
    repeat (4) tick();
    check("err_exit_busy", {31'd0, busy}, 32'd0);
    check("err_sticky", {31'd0, frame_err}, 32'd1);
    check("err_no_strobe", wq.size(), 0);
    check("err_no_done", done_cnt, 0);

    // Reset in the middle of a byte: no strobe, state cleared.
    csi = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      mosi = i[0];
      tick();
    end
    rst_n = 1'b0;
    repeat (2) tick();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_imem_addr", {28'd0, mem.imem_addr}, 32'd0);
    csi   = 1'b1;
    mosi  = 1'b0;
    rst_n = 1'b1;
    repeat (6) tick();
    check("midrst_no_strobe", wq.size(), 0);
    run_vec(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_loader.md
# spi_mem_loader

Serial loader that sits directly upstream of the tiny processor's instruction and data memories. It deserialises bytes arriving on `mosi` while one of the two chip-selects (`csi` for instructions, `csd` for data) is low. Each complete byte is written to the selected memory at an auto-incrementing address. Loading is locked out while `proc_en` is high, so the core never sees its memories change under it.

## Interface

Parameters:
- `IMEM_AW`, default 4: instruction memory address width (depth `2**IMEM_AW`).
- `DMEM_AW`, default 4: data memory address width (depth `2**DMEM_AW`).

Ports:
- `clk`, in, 1: system clock; also the serial bit clock (one bit per cycle).
- `rst_n`, in, 1: asynchronous active-low reset.
- `proc_en`, in, 1: processor running; loading is locked out while high.
- `csi`, in, 1: active-low instruction-frame select (raw pin).
- `csd`, in, 1: active-low data-frame select (raw pin).
- `mosi`, in, 1: serial data, MSB first (raw pin).
- `imem_we`, out, 1: instruction memory write strobe.
- `imem_addr`, out, `IMEM_AW`: instruction write address.
- `imem_wdata`, out, 8: instruction write byte.
- `dmem_we`, out, 1: data memory write strobe.
- `dmem_addr`, out, `DMEM_AW`: data write address.
- `dmem_wdata`, out, 8: data write byte.
- `busy`, out, 1: a frame is in progress.
- `load_done`, out, 1: one-cycle pulse at the close of a frame that wrote at least one byte.
- `overflow`, out, 1: sticky; the frame sent more bytes than the memory depth.
- `frame_err`, out, 1: sticky; both selects were low together.
- `checksum`, out, 8: XOR of all bytes written in the current or last frame (see Configuration).

## Operation

Input synchronisation:
- `csi`, `csd` and `mosi` each pass through a 2-flop synchroniser of identical depth, so relative alignment is preserved.
- All logic below uses the synchronised versions, written `csi_s`, `csd_s`, `mosi_s`.

FSM states: IDLE, LOAD_I, LOAD_D, ERR, LOCKED.
- **IDLE**:
  - `proc_en`=1 goes to LOCKED.
  - `csi_s`=0 with `csd_s`=1 goes to LOAD_I.
  - `csd_s`=0 with `csi_s`=1 goes to LOAD_D.
  - Both low goes to ERR.
  - On frame entry: bit counter, address and checksum clear to 0; `overflow` and `frame_err` clear to 0.
- **LOAD_I / LOAD_D**:
  - Each cycle with the select low: shift `sr <= {sr[6:0], mosi_s}` and increment the 3-bit bit counter.
  - On the 8th bit, the byte is complete. If the address has not passed the last location, pulse `*_we` next cycle with `*_wdata` = byte and `*_addr` = current address; the address increments after the write.
  - A byte beyond the depth is dropped (no strobe) and sets `overflow`. The address does not wrap.
  - Select rises: return to IDLE. A partial byte is discarded. `load_done` pulses if at least one byte was written.
  - The other select falling mid-frame: go to ERR and discard the partial byte.
- **ERR**:
  - `frame_err` is set and no writes occur.
  - Return to IDLE when both selects are high.
- **LOCKED**:
  - Entered from IDLE when `proc_en`=1. Selects are ignored and no strobes occur.
  - Exit to IDLE when `proc_en`=0 and both selects are high.
  - `proc_en` rising mid-frame does not abort the frame. The lock takes effect at the next IDLE.

Output rules:
- `busy` is high in LOAD_I, LOAD_D and ERR.
- `imem_we` and `dmem_we` are never high in the same cycle.

## Timing

- Reset values: FSM=IDLE, synchronisers=1 (selects) and 0 (`mosi`). All outputs are 0, including addresses, wdata, strobes, `busy`, `load_done`, `overflow`, `frame_err` and `checksum`.
- Pin-to-logic latency is 2 cycles.
- Write strobe asserts 1 cycle after the 8th synchronised bit is sampled, which is 3 cycles after the 8th bit appears on the pin.
- The strobe is 1 cycle wide. `*_addr` and `*_wdata` are stable during the strobe and hold until the next write.
- Back-to-back bytes produce one strobe every 8 cycles with no gap.
- `load_done` asserts in the cycle after `csi_s`/`csd_s` is sampled high.
- Reset mid-frame aborts immediately: no strobe, counters cleared.

## Configuration

- `LOADER_CHECKSUM_EN` defined:
  - `checksum` holds the XOR of every byte actually written in the frame.
  - It updates in the strobe cycle, clears at frame start, and holds after the frame ends.
- Not defined: `checksum` is tied to 8'h00 and no checksum register is synthesised.

## Test plan

1. Reset with all inputs idle: every output is 0 and the FSM is IDLE; release reset, hold 10 cycles, no strobes.
2. `csi` low, shift 8'hA5 then 8'h3C, `csi` high: `imem_we` pulses twice, (addr 0, A5) then (addr 1, 3C); `load_done` pulses once; `checksum`=8'h99 with the macro, 8'h00 without.
3. `csd` low, shift 17 bytes into a 16-deep memory: 16 `dmem_we` pulses at addresses 0..15; the 17th byte is dropped and `overflow`=1; `load_done` pulses.
4. `csi` low, 5 bits shifted, `csi` high: no strobe, no `load_done`; the next frame writes at addr 0.
5. `csi` low, then `csd` low mid-byte: `frame_err`=1, no strobe, `busy` holds until both are high, then IDLE.
6. `proc_en`=1 while IDLE, then a full `csi` frame with 8'hFF: no `imem_we`; drop `proc_en` and resend the frame: write to addr 0 with 8'hFF.
